// File: rtl/javk_alu_ctrl.sv
// JAVK 8-bit CPU execution core: 3-state fetch/decode/exec sequencer
// driving register-file selects and a registered 8-bit ALU.
module javk_alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       fetch,
  output logic [2:0] alu_op,
  output logic [2:0] alu_shamt,
  output logic [3:0] reg_sel,
  output logic [1:0] reg16_src,
  output logic [1:0] reg16_dst,
  output logic       reg16_mv,
  output logic       alu_en,
  output logic [7:0] alu_out,
  output logic [3:0] flags
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  state_t     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [2:0] shamt_q, shamt_d;
  logic [3:0] reg_sel_q, reg_sel_d;
  logic [1:0] src_q, src_d;
  logic [1:0] dst_q, dst_d;
  logic [7:0] alu_out_q, alu_out_d;
  logic [3:0] flags_q, flags_d;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // ---------------- decode ----------------
  // Decode outputs change only on the edge that ends DECODE; NOPs and
  // moves leave the fields they do not own untouched.
  always_comb begin
    instr_d   = instr_q;
    alu_op_d  = alu_op_q;
    shamt_d   = shamt_q;
    reg_sel_d = reg_sel_q;
    src_d     = src_q;
    dst_d     = dst_q;
    if (state_q == S_DECODE) begin
      instr_d = instr;
      if (instr[7]) begin
        alu_op_d  = instr[6:4];
        reg_sel_d = instr[3:0];
        shamt_d   = instr[2:0];
      end else if (instr[6]) begin
        src_d = instr[3:2];
        dst_d = instr[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      alu_op_q  <= '0;
      shamt_q   <= '0;
      reg_sel_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
    end else begin
      instr_q   <= instr_d;
      alu_op_q  <= alu_op_d;
      shamt_q   <= shamt_d;
      reg_sel_q <= reg_sel_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
    end
  end

  // Strobes come from the latched instruction, so they are mutually exclusive.
  assign fetch    = (state_q == S_FETCH);
  assign alu_en   = (state_q == S_EXEC) && instr_q[7];
  assign reg16_mv = (state_q == S_EXEC) && (instr_q[7:6] == 2'b01);

  assign alu_op    = alu_op_q;
  assign alu_shamt = shamt_q;
  assign reg_sel   = reg_sel_q;
  assign reg16_src = src_q;
  assign reg16_dst = dst_q;

  // ---------------- ALU ----------------
  logic [8:0] sum_w, diff_w, shl_w, shr_w;
  logic [7:0] res;
  logic       res_c, res_v;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  // Extra bit catches the last bit shifted out (zero when shamt=0).
  assign shl_w  = {1'b0, a} << shamt_q;
  assign shr_w  = {a, 1'b0} >> shamt_q;

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (alu_op_q)
      OP_ADD: begin
        res   = sum_w[7:0];
        res_c = sum_w[8];
        res_v = (a[7] == b[7]) && (sum_w[7] != a[7]);
      end
      OP_SUB: begin
        res   = diff_w[7:0];
        res_c = diff_w[8];
        res_v = (a[7] != b[7]) && (diff_w[7] != a[7]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res   = shl_w[7:0];
        res_c = shl_w[8];
      end
      OP_SHR: begin
        res   = shr_w[8:1];
        res_c = shr_w[0];
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    alu_out_d = alu_out_q;
    flags_d   = flags_q;
    if (alu_en) begin
      alu_out_d = res;
      flags_d   = {res[7], res_v, res_c, (res == 8'h00)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      flags_q   <= '0;
    end else begin
      alu_out_q <= alu_out_d;
      flags_q   <= flags_d;
    end
  end

  assign alu_out = alu_out_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_javk_alu_ctrl.sv
// Scoreboard bench for javk_alu_ctrl: walks each instruction through
// FETCH/DECODE/EXEC and checks decode outputs, strobes and ALU results.
module tb_javk_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr, a, b;
  logic       fetch, reg16_mv, alu_en;
  logic [2:0] alu_op, alu_shamt;
  logic [3:0] reg_sel, flags;
  logic [1:0] reg16_src, reg16_dst;
  logic [7:0] alu_out;

  int n_cmp = 0;
  int n_err = 0;

  // held-output model
  logic [2:0]  e_op, e_sh;
  logic [3:0]  e_sel, e_flags;
  logic [1:0]  e_src, e_dst;
  logic [7:0]  e_out;
  logic [11:0] sb[$];

  javk_alu_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .a(a), .b(b),
    .fetch(fetch), .alu_op(alu_op), .alu_shamt(alu_shamt), .reg_sel(reg_sel),
    .reg16_src(reg16_src), .reg16_dst(reg16_dst), .reg16_mv(reg16_mv),
    .alu_en(alu_en), .alu_out(alu_out), .flags(flags)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model_alu(input logic [2:0] op, input logic [7:0] x,
                                            input logic [7:0] y, input logic [2:0] s);
    int r, sr, si;
    logic c, v;
    logic [7:0] o;
    c = 1'b0; v = 1'b0; r = 0; si = int'(s);
    case (op)
      3'd0: begin
        r = int'(x) + int'(y);
        sr = int'($signed(x)) + int'($signed(y));
        c = (r > 255); v = (sr > 127) || (sr < -128);
      end
      3'd1: begin
        r = int'(x) - int'(y);
        sr = int'($signed(x)) - int'($signed(y));
        c = (x < y); v = (sr > 127) || (sr < -128);
      end
      3'd2: r = int'(x & y);
      3'd3: r = int'(x | y);
      3'd4: r = int'(x ^ y);
      3'd5: r = int'(~x);
      3'd6: begin r = int'(x) << si; if (si != 0) c = x[8 - si]; end
      default: begin r = int'(x) >> si; if (si != 0) c = x[si - 1]; end
    endcase
    o = r[7:0];
    return {o[7], v, c, (o == 8'h00), o};
  endfunction

  task automatic clear_model();
    e_op = '0; e_sh = '0; e_sel = '0; e_src = '0; e_dst = '0;
    e_out = '0; e_flags = '0;
    sb.delete();
  endtask

  // Called just after an edge; drives one instruction through all 3 states.
  task automatic run_instr(input logic [7:0] i, input logic [7:0] av, input logic [7:0] bv);
    int w;
    logic [11:0] exp;
    w = 0;
    while (fetch !== 1'b1 && w < 4) begin @(posedge clk); #1; w++; end
    n_cmp++;
    if (fetch !== 1'b1) begin n_err++; $display("FAIL fetch_wait instr=%h got=%b want=1", i, fetch); end
    instr = i; a = av; b = bv;
    @(posedge clk); #1;  // DECODE
    n_cmp++;
    if ({fetch, alu_en, reg16_mv} !== 3'b000) begin
      n_err++; $display("FAIL decode_strobes instr=%h got=%b want=000", i, {fetch, alu_en, reg16_mv});
    end
    if (i[7]) begin
      e_op = i[6:4]; e_sel = i[3:0]; e_sh = i[2:0];
      sb.push_back(model_alu(e_op, av, bv, e_sh));
    end else if (i[6]) begin
      e_src = i[3:2]; e_dst = i[1:0];
    end
    @(posedge clk); #1;  // EXEC
    n_cmp++;
    if ({alu_op, reg_sel, alu_shamt, reg16_src, reg16_dst} !== {e_op, e_sel, e_sh, e_src, e_dst}) begin
      n_err++;
      $display("FAIL decode_out instr=%h got op=%0d sel=%0d sh=%0d src=%0d dst=%0d want op=%0d sel=%0d sh=%0d src=%0d dst=%0d",
               i, alu_op, reg_sel, alu_shamt, reg16_src, reg16_dst, e_op, e_sel, e_sh, e_src, e_dst);
    end
    n_cmp++;
    if ({fetch, alu_en, reg16_mv} !== {1'b0, i[7], (i[7:6] == 2'b01)}) begin
      n_err++;
      $display("FAIL exec_strobes instr=%h got=%b want=%b", i, {fetch, alu_en, reg16_mv},
               {1'b0, i[7], (i[7:6] == 2'b01)});
    end
    @(posedge clk); #1;  // next FETCH
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      e_flags = exp[11:8]; e_out = exp[7:0];
    end
    n_cmp++;
    if (alu_out !== e_out || flags !== e_flags) begin
      n_err++;
      $display("FAIL alu_result instr=%h a=%h b=%h got out=%h flags=%b want out=%h flags=%b",
               i, av, bv, alu_out, flags, e_out, e_flags);
    end
    n_cmp++;
    if ({fetch, alu_en, reg16_mv} !== 3'b100) begin
      n_err++; $display("FAIL fetch_strobes instr=%h got=%b want=100", i, {fetch, alu_en, reg16_mv});
    end
  endtask

  task automatic test_reset();
    logic [5:0] seq;
    rst = 1'b1; instr = 8'h00; a = 8'h00; b = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    n_cmp++;
    if ({alu_out, flags, alu_op, alu_shamt, reg_sel, reg16_src, reg16_dst, alu_en, reg16_mv} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got out=%h flags=%b op=%0d sh=%0d sel=%0d src=%0d dst=%0d en=%b mv=%b want all 0",
               alu_out, flags, alu_op, alu_shamt, reg_sel, reg16_src, reg16_dst, alu_en, reg16_mv);
    end
    for (int k = 0; k < 6; k++) begin
      seq[5 - k] = fetch;
      if (k < 5) begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (seq !== 6'b100100) begin n_err++; $display("FAIL reset_fetch_seq got=%b want=100100", seq); end
    @(posedge clk); #1;  // back in FETCH
  endtask

  task automatic test_add_carry();
    run_instr(8'h83, 8'hFF, 8'h01);
    n_cmp++;
    if (alu_out !== 8'h00 || flags !== 4'b0011 || reg_sel !== 4'd3 || alu_op !== 3'd0) begin
      n_err++; $display("FAIL add_carry got out=%h flags=%b sel=%0d op=%0d want out=00 flags=0011 sel=3 op=0",
                        alu_out, flags, reg_sel, alu_op);
    end
    run_instr(8'h85, 8'h7F, 8'h01);
  endtask

  task automatic test_sub_overflow();
    run_instr(8'h90, 8'h80, 8'h01);
    n_cmp++;
    if (alu_out !== 8'h7F || flags !== 4'b0100) begin
      n_err++; $display("FAIL sub_ovf got out=%h flags=%b want out=7F flags=0100", alu_out, flags);
    end
    run_instr(8'h90, 8'h00, 8'h01);
    n_cmp++;
    if (alu_out !== 8'hFF || flags !== 4'b1010) begin
      n_err++; $display("FAIL sub_borrow got out=%h flags=%b want out=FF flags=1010", alu_out, flags);
    end
  endtask

  task automatic test_shifts();
    run_instr(8'hE3, 8'h21, 8'h5C);
    n_cmp++;
    if (alu_out !== 8'h08 || flags !== 4'b0010) begin
      n_err++; $display("FAIL shl3 got out=%h flags=%b want out=08 flags=0010", alu_out, flags);
    end
    run_instr(8'hF1, 8'h01, 8'hA7);
    n_cmp++;
    if (alu_out !== 8'h00 || flags !== 4'b0011) begin
      n_err++; $display("FAIL shr1 got out=%h flags=%b want out=00 flags=0011", alu_out, flags);
    end
    run_instr(8'hE0, 8'hB5, 8'h00);
    n_cmp++;
    if (alu_out !== 8'hB5 || flags !== 4'b1000) begin
      n_err++; $display("FAIL shl0 got out=%h flags=%b want out=B5 flags=1000", alu_out, flags);
    end
    run_instr(8'hE7, 8'h81, 8'h00);
    run_instr(8'hF7, 8'h81, 8'h00);
  endtask

  task automatic test_logic_ops();
    run_instr(8'hA2, 8'hF0, 8'h3C);
    run_instr(8'hB4, 8'hF0, 8'h0F);
    run_instr(8'hC6, 8'hAA, 8'hAA);
    run_instr(8'hD9, 8'h0F, 8'h12);
  endtask

  task automatic test_move_nop();
    logic [7:0] held;
    held = alu_out;
    run_instr(8'h4E, 8'h13, 8'h57);
    n_cmp++;
    if (reg16_src !== 2'd3 || reg16_dst !== 2'd2 || alu_out !== held) begin
      n_err++; $display("FAIL move got src=%0d dst=%0d out=%h want src=3 dst=2 out=%h",
                        reg16_src, reg16_dst, alu_out, held);
    end
    run_instr(8'h00, 8'h99, 8'h66);
    run_instr(8'h3F, 8'h01, 8'h01);
    run_instr(8'h71, 8'h00, 8'h00);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++)
      run_instr(8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_mid_reset();
    run_instr(8'h80, 8'h20, 8'h03);  // leave a nonzero result behind
    instr = 8'h80; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;  // DECODE
    @(posedge clk); #1;  // EXEC
    rst = 1'b1;
    @(posedge clk); #1;
    clear_model();
    n_cmp++;
    if ({alu_out, flags, alu_op, alu_shamt, reg_sel, reg16_src, reg16_dst, alu_en, reg16_mv} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs got out=%h flags=%b op=%0d sh=%0d sel=%0d src=%0d dst=%0d en=%b mv=%b want all 0",
               alu_out, flags, alu_op, alu_shamt, reg_sel, reg16_src, reg16_dst, alu_en, reg16_mv);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (fetch !== 1'b1) begin n_err++; $display("FAIL mid_reset_fetch got=%b want=1", fetch); end
    @(posedge clk); #1;
    n_cmp++;
    if (fetch !== 1'b0) begin n_err++; $display("FAIL mid_reset_decode got=%b want=0", fetch); end
    @(posedge clk); @(posedge clk); #1;
    run_instr(8'h80, 8'h10, 8'h20);
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_overflow();
    test_shifts();
    test_logic_ops();
    test_move_nop();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/javk_alu_ctrl.md
Name: javk_alu_ctrl

Overview:
- Combined execution core of the JAVK 8-bit CPU: instruction sequencer/decoder (ctrl) plus registered 8-bit ALU (alu).
- Sequencer runs a fixed 3-state loop (FETCH, DECODE, EXEC). It asks the CPU shell for an instruction byte, decodes it, and drives ALU and register-file selects.
- ALU combines accumulator `a` with register operand `b`; result and flags are registered.
- Sits between the CPU shell (memory bus, PC, register file) and the register file.

Parameters:
- none (8-bit datapath, 16-entry register file, 4 16-bit register pairs are fixed)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  8  instruction byte from shell; must be valid during the DECODE cycle
- a  in  8  accumulator value (register file entry A)
- b  in  8  ALU second operand (shell drives regfile[reg_sel])
- fetch  out  1  high during the FETCH cycle: shell must place the memory byte at PC on instr and increment PC
- alu_op  out  3  decoded ALU operation (registered)
- alu_shamt  out  3  decoded shift amount (registered)
- reg_sel  out  4  register-file index for operand b (registered)
- reg16_src  out  2  16-bit move source pair (registered)
- reg16_dst  out  2  16-bit move destination pair (registered)
- reg16_mv  out  1  one-cycle strobe in EXEC for a 16-bit move
- alu_en  out  1  one-cycle strobe in EXEC for an ALU instruction
- alu_out  out  8  registered ALU result
- flags  out  4  registered flags: [3]=N, [2]=V, [1]=C, [0]=Z

Behaviour:
- Reset (rst=1 at a rising edge) has priority over everything, including mid-instruction:
  - state <= FETCH; all registered outputs and the instr latch <= 0; alu_out=0, flags=4'b0000.
- After reset, the sequencer loops FETCH -> DECODE -> EXEC -> FETCH, one cycle each, 3 cycles per instruction. No stalls.
- fetch is combinational from state: 1 only in FETCH, so the first cycle after reset release has fetch=1.
- At the rising edge ending DECODE, the block latches instr and updates the decode outputs. They hold until the next DECODE edge.
- Instruction encoding:
  - 1ooo_rrrr (ALU):
    - alu_op=ooo, reg_sel=rrrr, alu_shamt=instr[2:0].
    - alu_en=1 in EXEC.
    - For op 5, 6 and 7, operand b is ignored.
  - 01xx_sstt (16-bit move):
    - reg16_src=ss, reg16_dst=tt.
    - reg16_mv=1 in EXEC.
    - Bits [5:4] are ignored.
    - alu_op, reg_sel and alu_shamt keep their previous values.
  - 00xx_xxxx: NOP. No strobe in EXEC; all decode outputs keep their previous values.
- ALU operations (alu_op):
  - 0 ADD: out = a+b; C = carry out of bit 7; V = signed overflow.
  - 1 SUB: out = a-b; C = borrow (a<b unsigned); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise; C=0, V=0.
  - 5 NOT: out = ~a; C=0, V=0.
  - 6 SHL: out = a<<shamt (zero fill); C = last bit shifted out, i.e. a[8-shamt], or 0 when shamt=0; V=0.
  - 7 SHR: logical, out = a>>shamt; C = a[shamt-1], or 0 when shamt=0; V=0.
  - All ops: Z = (out==0); N = out[7]. All results are truncated to 8 bits.
- ALU register timing:
  - alu_out and flags update only at the rising edge ending an EXEC cycle with alu_en=1.
  - They use the a and b values present in that EXEC cycle.
  - New result is visible from the following FETCH cycle.
  - Otherwise alu_out and flags hold.
- alu_en and reg16_mv are never both high, and are 0 outside EXEC.

Test Plan:
- Reset/sequence: hold rst 2 cycles, release.
  - Required: fetch=1 in cycle 1, then 0,0,1,0,0,... (period 3).
  - alu_out=0x00 and flags=0 immediately after reset.
- ADD carry: instr=0x83 (ADD, reg_sel=3), a=0xFF, b=0x01.
  - Required: reg_sel=3, alu_op=0 after DECODE, alu_en pulse.
  - Then alu_out=0x00, flags=0011 (C, Z).
- SUB overflow: instr=0x90, a=0x80, b=0x01.
  - Required: alu_out=0x7F, flags=0100 (V).
  - Then a=0x00, b=0x01: alu_out=0xFF, flags=1010 (N, C).
- Shifts: instr=0xE3 (SHL 3), a=0x21 -> alu_out=0x08, C=1.
  - instr=0xF1 (SHR 1), a=0x01 -> alu_out=0x00, flags=0011.
  - instr=0xE0 (SHL 0) -> out=a, C=0.
- 16-bit move/NOP: instr=0x4E.
  - Required: reg16_src=3, reg16_dst=2, reg16_mv pulses for one cycle, alu_out unchanged.
  - Then instr=0x00: no strobes, all outputs held.
- Mid-instruction reset: assert rst during EXEC of an ADD.
  - Required: no alu_out update, all outputs 0, state returns to FETCH (fetch=1 in the cycle after rst release).
